// File: rtl/time_keeper_if.sv
// Frame-in / time-out bundle between the SPI frame receiver, time_keeper and the VGA face renderer.
// The receiver side is the master; time_keeper is the slave.
interface time_keeper_if;
    logic       load;
    logic       header_in;
    logic [4:0] hour_in;
    logic [5:0] minute_in;
    logic [5:0] second_in;
    logic [3:0] month_in;
    logic [4:0] day_in;
    logic [4:0] year_in;

    logic [4:0] hour;
    logic       pm;
    logic [5:0] minute;
    logic [5:0] second;
    logic [3:0] month;
    logic [4:0] day;
    logic [4:0] year;
    logic       syncing;
    logic       valid;
    logic       tick;
    logic       load_err;

    modport master (
        output load, header_in, hour_in, minute_in, second_in, month_in, day_in, year_in,
        input  hour, pm, minute, second, month, day, year, syncing, valid, tick, load_err
    );

    modport slave (
        input  load, header_in, hour_in, minute_in, second_in, month_in, day_in, year_in,
        output hour, pm, minute, second, month, day, year, syncing, valid, tick, load_err
    );
endinterface

// File: rtl/time_keeper.sv
// Free-running calendar clock (2000-2031), loaded from decoded sync frames, advanced by a 1 Hz prescaler.
// Loads take effect on the sampling edge; every output is a register so the time set is always consistent.
module time_keeper #(
    parameter int CLK_HZ = 40_000_000
) (
    input  logic          clk,
    input  logic          reset,
    time_keeper_if.slave  tk
);
    localparam int            PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [4:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            4'd2:                    days_in_month = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

    logic [PW-1:0] presc;
    logic [4:0]    hour_q, day_q, year_q;
    logic          pm_q;
    logic [5:0]    min_q, sec_q;
    logic [3:0]    mon_q;
    logic          syncing_q, valid_q, tick_q, load_err_q;

    logic [4:0]    n_hour, n_day, n_year;
    logic          n_pm;
    logic [5:0]    n_min, n_sec;
    logic [3:0]    n_mon;

    logic          terminal;
    logic          fields_ok;
    logic          accept;

    assign terminal  = (presc == TERM);
    assign fields_ok = (tk.hour_in < 5'd24) && (tk.minute_in < 6'd60) && (tk.second_in < 6'd60)
                    && (tk.month_in != 4'd0) && (tk.month_in <= 4'd12)
                    && (tk.day_in != 5'd0) && (tk.day_in <= days_in_month(tk.month_in, tk.year_in));
    assign accept    = tk.load && !tk.header_in && fields_ok;

    // Hour is kept as 12-hour value plus pm flag, so 11 -> 0 toggles pm and pm 11 -> am 0 rolls the day.
    always_comb begin
        n_sec  = sec_q + 6'd1;
        n_min  = min_q;
        n_hour = hour_q;
        n_pm   = pm_q;
        n_day  = day_q;
        n_mon  = mon_q;
        n_year = year_q;
        if (sec_q == 6'd59) begin
            n_sec = 6'd0;
            n_min = min_q + 6'd1;
            if (min_q == 6'd59) begin
                n_min  = 6'd0;
                n_hour = hour_q + 5'd1;
                if (hour_q == 5'd11) begin
                    n_hour = 5'd0;
                    n_pm   = ~pm_q;
                    if (pm_q) begin
                        n_day = day_q + 5'd1;
                        if (day_q == days_in_month(mon_q, year_q)) begin
                            n_day = 5'd1;
                            n_mon = mon_q + 4'd1;
                            if (mon_q == 4'd12) begin
                                n_mon  = 4'd1;
                                n_year = year_q + 5'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            hour_q     <= 5'd0;
            pm_q       <= 1'b0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            mon_q      <= 4'd1;
            day_q      <= 5'd1;
            year_q     <= 5'd0;
            syncing_q  <= 1'b0;
            valid_q    <= 1'b0;
            tick_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tick_q     <= 1'b0;
            load_err_q <= 1'b0;
            if (accept) begin
                presc     <= '0;
                pm_q      <= (tk.hour_in >= 5'd12);
                hour_q    <= (tk.hour_in >= 5'd12) ? tk.hour_in - 5'd12 : tk.hour_in;
                min_q     <= tk.minute_in;
                sec_q     <= tk.second_in;
                mon_q     <= tk.month_in;
                day_q     <= tk.day_in;
                year_q    <= tk.year_in;
                syncing_q <= 1'b0;
                valid_q   <= 1'b1;
            end else begin
                if (tk.load) begin
                    syncing_q  <= tk.header_in;
                    load_err_q <= !tk.header_in;
                end
                if (terminal) begin
                    presc  <= '0;
                    tick_q <= 1'b1;
                    hour_q <= n_hour;
                    pm_q   <= n_pm;
                    min_q  <= n_min;
                    sec_q  <= n_sec;
                    mon_q  <= n_mon;
                    day_q  <= n_day;
                    year_q <= n_year;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    assign tk.hour     = hour_q;
    assign tk.pm       = pm_q;
    assign tk.minute   = min_q;
    assign tk.second   = sec_q;
    assign tk.month    = mon_q;
    assign tk.day      = day_q;
    assign tk.year     = year_q;
    assign tk.syncing  = syncing_q;
    assign tk.valid    = valid_q;
    assign tk.tick     = tick_q;
    assign tk.load_err = load_err_q;
endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with CLK_HZ=4; inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_time_keeper;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    time_keeper_if tk();

    time_keeper #(.CLK_HZ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .tk    (tk)
    );

    always #5 clk = ~clk;

    logic [31:0] now_t;
    assign now_t = {tk.year, tk.month, tk.day, tk.pm, tk.hour, tk.minute, tk.second};

    function automatic logic [31:0] pk(int y, int mo, int d, int h24, int mi, int s);
        return {5'(y), 4'(mo), 5'(d), (h24 >= 12), 5'(h24 % 12), 6'(mi), 6'(s)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic hdr, input int y, input int mo, input int d,
                           input int h, input int mi, input int s);
        tk.load      = 1'b1;
        tk.header_in = hdr;
        tk.year_in   = 5'(y);
        tk.month_in  = 4'(mo);
        tk.day_in    = 5'(d);
        tk.hour_in   = 5'(h);
        tk.minute_in = 6'(mi);
        tk.second_in = 6'(s);
        step();
        tk.load = 1'b0;
    endtask

    task automatic test_reset();
        int ticks = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (now_t !== pk(0, 1, 1, 0, 0, 0)) begin
            fails++; $display("FAIL reset_time got %h want %h", now_t, pk(0, 1, 1, 0, 0, 0));
        end
        checks++;
        if ({tk.valid, tk.syncing, tk.tick, tk.load_err} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {tk.valid, tk.syncing, tk.tick, tk.load_err});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            ticks += int'(tk.tick);
        end
        checks++;
        if (ticks !== 1 || tk.tick !== 1'b1 || tk.second !== 6'd1) begin
            fails++; $display("FAIL reset_first_tick ticks %0d tick %b sec %0d want 1 1 1", ticks, tk.tick, tk.second);
        end
    endtask

    task automatic test_full_carry();
        int ticks = 0;
        do_load(1'b0, 31, 12, 31, 23, 59, 59);
        checks++;
        if ({tk.valid, tk.hour, tk.pm, tk.load_err} !== {1'b1, 5'd11, 1'b1, 1'b0}) begin
            fails++; $display("FAIL carry_load valid %b hour %0d pm %b err %b want 1 11 1 0", tk.valid, tk.hour, tk.pm, tk.load_err);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            ticks += int'(tk.tick);
        end
        checks++;
        if (now_t !== pk(0, 1, 1, 0, 0, 0) || ticks !== 1) begin
            fails++; $display("FAIL full_carry got %h ticks %0d want %h ticks 1", now_t, ticks, pk(0, 1, 1, 0, 0, 0));
        end
    endtask

    task automatic test_leap();
        do_load(1'b0, 4, 2, 28, 23, 59, 59);
        repeat (4) step();
        checks++;
        if (now_t !== pk(4, 2, 29, 0, 0, 0)) begin
            fails++; $display("FAIL leap_2004 got %h want %h", now_t, pk(4, 2, 29, 0, 0, 0));
        end
        do_load(1'b0, 5, 2, 28, 23, 59, 59);
        repeat (4) step();
        checks++;
        if (now_t !== pk(5, 3, 1, 0, 0, 0)) begin
            fails++; $display("FAIL nonleap_2005 got %h want %h", now_t, pk(5, 3, 1, 0, 0, 0));
        end
    endtask

    // Entry state: 2005-03-01 00:00:00 with prescaler just wrapped to 0.
    task automatic test_reject();
        do_load(1'b0, 10, 4, 31, 5, 5, 5);
        checks++;
        if (tk.load_err !== 1'b1 || now_t !== pk(5, 3, 1, 0, 0, 0)) begin
            fails++; $display("FAIL reject_day err %b time %h want 1 %h", tk.load_err, now_t, pk(5, 3, 1, 0, 0, 0));
        end
        step();
        checks++;
        if (tk.load_err !== 1'b0) begin
            fails++; $display("FAIL reject_pulse_width err %b want 0", tk.load_err);
        end
        repeat (2) step();
        checks++;
        if (tk.tick !== 1'b1 || now_t !== pk(5, 3, 1, 0, 0, 1)) begin
            fails++; $display("FAIL reject_still_running tick %b time %h want 1 %h", tk.tick, now_t, pk(5, 3, 1, 0, 0, 1));
        end
        do_load(1'b0, 10, 6, 15, 10, 60, 0);
        checks++;
        if (tk.load_err !== 1'b1 || now_t !== pk(5, 3, 1, 0, 0, 1)) begin
            fails++; $display("FAIL reject_minute err %b time %h want 1 %h", tk.load_err, now_t, pk(5, 3, 1, 0, 0, 1));
        end
        repeat (3) step();
        checks++;
        if (now_t !== pk(5, 3, 1, 0, 0, 2)) begin
            fails++; $display("FAIL reject_minute_running got %h want %h", now_t, pk(5, 3, 1, 0, 0, 2));
        end
        do_load(1'b0, 5, 2, 29, 1, 1, 1);
        checks++;
        if (tk.load_err !== 1'b1 || tk.month !== 4'd3) begin
            fails++; $display("FAIL reject_feb29_nonleap err %b month %0d want 1 3", tk.load_err, tk.month);
        end
    endtask

    task automatic test_header();
        reset = 1'b1;
        step();
        reset = 1'b0;
        do_load(1'b1, 31, 15, 0, 31, 63, 63);
        checks++;
        if ({tk.syncing, tk.valid, tk.load_err} !== 3'b100) begin
            fails++; $display("FAIL header_flags got %b want 100", {tk.syncing, tk.valid, tk.load_err});
        end
        repeat (3) step();
        checks++;
        if (tk.tick !== 1'b1 || now_t !== pk(0, 1, 1, 0, 0, 1) || tk.syncing !== 1'b1) begin
            fails++; $display("FAIL header_running tick %b time %h sync %b want 1 %h 1", tk.tick, now_t, tk.syncing, pk(0, 1, 1, 0, 0, 1));
        end
        do_load(1'b0, 20, 7, 4, 13, 45, 30);
        checks++;
        if (tk.syncing !== 1'b0 || tk.valid !== 1'b1 || now_t !== pk(20, 7, 4, 13, 45, 30)) begin
            fails++; $display("FAIL header_then_valid sync %b valid %b time %h want 0 1 %h", tk.syncing, tk.valid, now_t, pk(20, 7, 4, 13, 45, 30));
        end
    endtask

    // Entry: accepted load one edge ago, prescaler 0; three edges bring it to terminal count.
    task automatic test_load_at_terminal();
        int first_tick = -1;
        repeat (3) step();
        do_load(1'b0, 8, 9, 10, 6, 7, 8);
        checks++;
        if (tk.tick !== 1'b0 || now_t !== pk(8, 9, 10, 6, 7, 8)) begin
            fails++; $display("FAIL terminal_load tick %b time %h want 0 %h", tk.tick, now_t, pk(8, 9, 10, 6, 7, 8));
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            if (tk.tick === 1'b1 && first_tick < 0) first_tick = i;
        end
        checks++;
        if (first_tick !== 4 || tk.second !== 6'd9) begin
            fails++; $display("FAIL terminal_next_tick at %0d sec %0d want 4 9", first_tick, tk.second);
        end
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        step();
        reset = 1'b0;
        do_load(1'b0, 1, 1, 1, 1, 1, 1);
        do_load(1'b0, 2, 2, 2, 2, 2, 2);
        checks++;
        if (now_t !== pk(2, 2, 2, 2, 2, 2) || tk.valid !== 1'b1) begin
            fails++; $display("FAIL back_to_back got %h valid %b want %h 1", now_t, tk.valid, pk(2, 2, 2, 2, 2, 2));
        end
        repeat (3) step();
        do_load(1'b0, 9, 9, 9, 9, 60, 9);
        checks++;
        if (tk.load_err !== 1'b1 || tk.tick !== 1'b1 || now_t !== pk(2, 2, 2, 2, 2, 3)) begin
            fails++; $display("FAIL reject_at_terminal err %b tick %b time %h want 1 1 %h", tk.load_err, tk.tick, now_t, pk(2, 2, 2, 2, 2, 3));
        end
        reset = 1'b1;
        do_load(1'b0, 7, 7, 7, 7, 7, 7);
        reset = 1'b0;
        checks++;
        if (now_t !== pk(0, 1, 1, 0, 0, 0) || {tk.valid, tk.load_err, tk.tick} !== 3'b000) begin
            fails++; $display("FAIL reset_beats_load time %h flags %b want %h 000", now_t, {tk.valid, tk.load_err, tk.tick}, pk(0, 1, 1, 0, 0, 0));
        end
    endtask

    initial begin
        reset        = 1'b1;
        tk.load      = 1'b0;
        tk.header_in = 1'b0;
        tk.hour_in   = '0;
        tk.minute_in = '0;
        tk.second_in = '0;
        tk.month_in  = 4'd1;
        tk.day_in    = 5'd1;
        tk.year_in   = '0;
        #1;
        test_reset();
        test_full_carry();
        test_leap();
        test_reject();
        test_header();
        test_load_at_terminal();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/time_keeper.md
# time_keeper

Free-running calendar clock that sits directly downstream of the SPI frame receiver. It takes a decoded time frame in the `clk` domain, loads it when the frame carries a valid last-sync time, and then advances seconds through years from a 1 Hz tick derived from `clk`. It drives the VGA face renderer with a stable, always-consistent time/date set.

## Interface

Parameters:
- `CLK_HZ`, default 40_000_000: `clk` cycles per second; prescaler terminal count is `CLK_HZ-1`.

Ports:
- `clk` input 1: system clock. One clock only.
- `reset` input 1: synchronous, active-high reset.
- `load` input 1: single-cycle strobe; frame fields below are valid in that cycle only.
- `header_in` input 1: 1 = sync in progress, 0 = fields hold last successful sync time.
- `hour_in` input 5: 0-23.
- `minute_in`, `second_in` input 6 each: 0-59.
- `month_in` input 4: 1-12.
- `day_in` input 5: 1 to days-in-month.
- `year_in` input 5: 0-31, meaning 2000-2031.
- `hour` output 5: 0-11, equal to hour24 mod 12.
- `pm` output 1: 1 when hour24 ≥ 12.
- `minute`, `second` output 6 each.
- `month` output 4, `day` output 5, `year` output 5.
- `syncing` output 1: last `header_in` sampled on `load`.
- `valid` output 1: at least one frame has been accepted since reset.
- `tick` output 1: one-cycle pulse, one per second.
- `load_err` output 1: one-cycle pulse when a frame is rejected.

## Operation

- **Reset.** Reset sets the following values on the next edge:
  - hour24=0, minute=0, second=0; month=1, day=1, year=0.
  - prescaler=0.
  - `syncing`=0, `valid`=0, `tick`=0, `load_err`=0.
- **Prescaler.** Counts 0..`CLK_HZ-1`, then wraps to 0. Width is `$clog2(CLK_HZ)`.
- **Advance.** On the edge where prescaler==`CLK_HZ-1`, the prescaler wraps and the time advances by exactly one second, with carries:
  - second 59→0 carries to minute.
  - minute 59→0 carries to hour24.
  - hour24 23→0 carries to day.
  - day equal to days-in-month →1 carries to month.
  - month 12→1 carries to year.
  - year 31→0 wraps; no flag.
- **Days-in-month.**
  - 30 for months 4, 6, 9, 11.
  - 29 for month 2 when year[1:0]==0; 28 for month 2 otherwise.
  - 31 for all other months.
- **Load, `header_in`=1.** Only `syncing`←1 is updated. Time, prescaler and `valid` are untouched, and the clock keeps running.
- **Load, `header_in`=0 with all fields in range.** The following happen on the same edge:
  - All time fields are overwritten.
  - prescaler←0.
  - `syncing`←0, `valid`←1.
- **Load, `header_in`=0 with any field out of range.** The whole frame is rejected:
  - Nothing is loaded.
  - `load_err` pulses for one cycle.
  - `syncing`←0.
  - Range checks include hour ≥24, minute/second ≥60, month 0 or >12, day 0 or > days-in-month of `month_in`/`year_in`.
- **Load coinciding with prescaler terminal count.**
  - Accepted load wins: no advance, no `tick`, prescaler←0.
  - Rejected load or `header_in`=1 load: the advance happens normally.
- **Consistency.** All outputs are registered and all fields update on the same edge. No partially carried time is ever visible.

## Timing

- The advance edge registers `tick`=1 for exactly the following cycle. The new second value is visible in that same cycle.
- `load` sampled at edge k: new fields, `syncing`, `valid` and `load_err` are visible from edge k onward (one-cycle latency).
- After an accepted load at edge k, the first `tick` and advance occur at edge k+`CLK_HZ`.
- A full carry (e.g. 2031-12-31 23:59:59 → 2000-01-01 00:00:00) completes in one edge.
- Reset asserted mid-count or during `load` beats everything: the reset values above appear on the next edge.
- `load` pulses on consecutive cycles are each evaluated independently; the last one wins.

## Test plan

All scenarios use `CLK_HZ`=4.

- **Reset.**
  - Stimulus: reset, then run 4 cycles.
  - Required response: 12:00:00 am state (hour=0, pm=0), 01/01/00, `valid`=0. After the 4 cycles, `tick` pulses once and second=1.
- **Load and full carry.**
  - Stimulus: load 2031-12-31 23:59:59 with header 0, then wait 4 cycles.
  - Required response: `valid`=1, hour=11, pm=1. After the wait: 2000-01-01, hour=0, pm=0, 00:00, with one `tick`.
- **Leap year.**
  - Stimulus: load 2004-02-28 23:59:59, run 1 s; then load 2005-02-28 23:59:59, run 1 s.
  - Required response: first case reaches 02/29; second case reaches 03/01.
- **Rejection.**
  - Stimulus: load day 31 with month 4.
  - Required response: `load_err` high for 1 cycle, time unchanged and still advancing.
  - Stimulus: load minute 60.
  - Required response: rejected the same way.
- **Header frame.**
  - Stimulus: load with header 1.
  - Required response: `syncing`=1, time keeps advancing, `valid` unchanged.
  - Stimulus: a following valid load.
  - Required response: clears `syncing`.
- **Load at terminal count.**
  - Stimulus: accepted load on the same cycle as prescaler==3.
  - Required response: no `tick` that cycle, loaded second unchanged, next `tick` exactly 4 cycles later.
